// File: rtl/nn_ctrl_pkg.sv
// Shared types and default constants for the neural-net memory controller.
// Optional feature macro used by the controller: NN_CTRL_CSB_GATE_EN.
package nn_ctrl_pkg;

  localparam int unsigned ADDR_W_D = 5;
  localparam int unsigned LEN_D    = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LEARN    = 2'b01,
    CLASSIFY = 2'b10
  } nn_state_t;

endpackage

// File: rtl/nn_burst_cnt.sv
// Wrapping burst counter: synchronous clear, increment, terminal-count flag.
module nn_burst_cnt
  import nn_ctrl_pkg::*;
#(
  parameter  int unsigned LEN = LEN_D,
  localparam int unsigned CW  = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          term
);

  // Terminal flag marks the last count of a burst.
  always_comb begin
    term = (cnt == CW'(LEN - 1));
  end

  // Count register: clear has priority, then wrapping increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= term ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/nn_mem_ctrl_param.sv
// Controller for kernel memory (KMEM) and dual-port weight memory (WMEM).
// LEARN writes a kernel slot plus weight pairs; CLASSIFY reads a kernel pair
// and walks the weights. Memory outputs are combinational from registered state.
// Macro NN_CTRL_CSB_GATE_EN: deselect memories in IDLE and drive oeb per port;
// when undefined all csb/oeb are tied low.
module nn_mem_ctrl_param
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_D,
  parameter int unsigned N_KERN    = 4,
  parameter int unsigned KSEL_W    = 3,
  parameter int unsigned LEARN_LEN = LEN_D,
  parameter int unsigned CLS_LEN   = LEN_D,
  parameter int unsigned EN_IDX    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              learn,
  input  logic              classify,
  input  logic [KSEL_W-1:0] kern_sel,
  output logic [ADDR_W-1:0] kmem_add1,
  output logic [ADDR_W-1:0] kmem_add2,
  output logic [ADDR_W-1:0] wmem_add1,
  output logic [ADDR_W-1:0] wmem_add2,
  output logic              kmem_web1,
  output logic              kmem_web2,
  output logic              wmem_web1,
  output logic              wmem_web2,
  output logic              kmem_oeb1,
  output logic              kmem_oeb2,
  output logic              kmem_csb1,
  output logic              kmem_csb2,
  output logic              wmem_oeb1,
  output logic              wmem_oeb2,
  output logic              wmem_csb1,
  output logic              wmem_csb2,
  output logic              en,
  output logic              learn_done,
  output logic              cls_done
);

  localparam int unsigned AW1  = ADDR_W + 1;
  localparam int unsigned WC_W = (LEARN_LEN > 1) ? $clog2(LEARN_LEN) : 1;
  localparam int unsigned RC_W = (CLS_LEN > 1) ? $clog2(CLS_LEN) : 1;
  localparam logic [KSEL_W-1:0] KSEL_MAX = KSEL_W'(N_KERN - 1);

  nn_state_t         state_q;
  nn_state_t         state_d;
  logic [KSEL_W-1:0] ksel_q;
  logic [WC_W-1:0]   wc;
  logic [RC_W-1:0]   rc;
  logic              wc_inc;
  logic              wc_clr;
  logic              wc_term;
  logic              rc_inc;
  logic              rc_clr;
  logic              rc_term;
  logic [AW1-1:0]    k_learn;
  logic [AW1-1:0]    k_pair;
  logic [AW1-1:0]    w_even;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: learn beats classify, otherwise fall back to IDLE.
  always_comb begin
    state_d = IDLE;
    if (learn) begin
      state_d = LEARN;
    end else if (classify) begin
      state_d = CLASSIFY;
    end
  end

  // Kernel slot is captured (clamped) only when entering an active state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ksel_q <= '0;
    end else if ((state_d != state_q) && (state_d != IDLE)) begin
      ksel_q <= (kern_sel > KSEL_MAX) ? KSEL_MAX : kern_sel;
    end
  end

  // A counter only runs while its state persists; any exit or entry restarts it at 0.
  always_comb begin
    wc_inc = (state_q == LEARN) && (state_d == LEARN);
    wc_clr = !wc_inc;
    rc_inc = (state_q == CLASSIFY) && (state_d == CLASSIFY);
    rc_clr = !rc_inc;
  end

  nn_burst_cnt #(.LEN(LEARN_LEN)) u_wc (
    .clk  (clk),
    .rst  (rst),
    .clr  (wc_clr),
    .inc  (wc_inc),
    .cnt  (wc),
    .term (wc_term)
  );

  nn_burst_cnt #(.LEN(CLS_LEN)) u_rc (
    .clk  (clk),
    .rst  (rst),
    .clr  (rc_clr),
    .inc  (rc_inc),
    .cnt  (rc),
    .term (rc_term)
  );

  // Address arithmetic carried one bit wider, then truncated (wraps mod 2**ADDR_W).
  always_comb begin
    k_learn = AW1'(ksel_q) * AW1'(LEARN_LEN) + AW1'(wc);
    k_pair  = AW1'(2) * AW1'(ksel_q);
    w_even  = AW1'(2) * AW1'(wc);
  end

  // Memory controls and pulses decoded from the registered state and counters.
  always_comb begin
    kmem_add1  = '0;
    kmem_add2  = '0;
    wmem_add1  = '0;
    wmem_add2  = '0;
    kmem_web1  = 1'b1;
    kmem_web2  = 1'b1;
    wmem_web1  = 1'b1;
    wmem_web2  = 1'b1;
    kmem_oeb1  = 1'b0;
    kmem_oeb2  = 1'b0;
    kmem_csb1  = 1'b0;
    kmem_csb2  = 1'b0;
    wmem_oeb1  = 1'b0;
    wmem_oeb2  = 1'b0;
    wmem_csb1  = 1'b0;
    wmem_csb2  = 1'b0;
    en         = 1'b0;
    learn_done = 1'b0;
    cls_done   = 1'b0;
    case (state_q)
      LEARN: begin
        kmem_add1  = ADDR_W'(k_learn);
        kmem_add2  = ADDR_W'(k_learn);
        kmem_web1  = 1'b0;
        wmem_add1  = ADDR_W'(w_even);
        wmem_add2  = ADDR_W'(w_even + AW1'(1));
        wmem_web1  = 1'b0;
        wmem_web2  = 1'b0;
        learn_done = wc_term;
`ifdef NN_CTRL_CSB_GATE_EN
        // Only KMEM port 2 is a read port during learn.
        kmem_oeb1  = 1'b1;
        wmem_oeb1  = 1'b1;
        wmem_oeb2  = 1'b1;
`endif
      end
      CLASSIFY: begin
        kmem_add1 = ADDR_W'(k_pair);
        kmem_add2 = ADDR_W'(k_pair + AW1'(1));
        wmem_add1 = ADDR_W'(AW1'(rc));
        wmem_add2 = ADDR_W'(AW1'(rc));
        en        = (rc == RC_W'(EN_IDX));
        cls_done  = rc_term;
      end
      default: begin
`ifdef NN_CTRL_CSB_GATE_EN
        kmem_oeb1 = 1'b1;
        kmem_oeb2 = 1'b1;
        kmem_csb1 = 1'b1;
        kmem_csb2 = 1'b1;
        wmem_oeb1 = 1'b1;
        wmem_oeb2 = 1'b1;
        wmem_csb1 = 1'b1;
        wmem_csb2 = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_nn_mem_ctrl_param.sv
// Self-checking bench for nn_mem_ctrl_param with a residency-based reference model.
module tb_nn_mem_ctrl_param;

  localparam int L_LEN = 4;
  localparam int C_LEN = 4;
  localparam int NK    = 4;
  localparam int AMOD  = 32;
  localparam int VW    = 35;

  logic       clk;
  logic       rst;
  logic       learn;
  logic       classify;
  logic [2:0] kern_sel;
  logic [4:0] kmem_add1, kmem_add2, wmem_add1, wmem_add2;
  logic kmem_web1, kmem_web2, wmem_web1, wmem_web2;
  logic kmem_oeb1, kmem_oeb2, kmem_csb1, kmem_csb2;
  logic wmem_oeb1, wmem_oeb2, wmem_csb1, wmem_csb2;
  logic en, learn_done, cls_done;

  int n_pass;
  int n_total;

  // Model: mode 0=idle 1=learn 2=classify, cycles resident, captured kernel slot.
  int m_mode;
  int m_n;
  int m_k;

  nn_mem_ctrl_param dut (
    .clk(clk), .rst(rst), .learn(learn), .classify(classify), .kern_sel(kern_sel),
    .kmem_add1(kmem_add1), .kmem_add2(kmem_add2), .wmem_add1(wmem_add1), .wmem_add2(wmem_add2),
    .kmem_web1(kmem_web1), .kmem_web2(kmem_web2), .wmem_web1(wmem_web1), .wmem_web2(wmem_web2),
    .kmem_oeb1(kmem_oeb1), .kmem_oeb2(kmem_oeb2), .kmem_csb1(kmem_csb1), .kmem_csb2(kmem_csb2),
    .wmem_oeb1(wmem_oeb1), .wmem_oeb2(wmem_oeb2), .wmem_csb1(wmem_csb1), .wmem_csb2(wmem_csb2),
    .en(en), .learn_done(learn_done), .cls_done(cls_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [VW-1:0] act_vec();
    return {kmem_add1, kmem_add2, wmem_add1, wmem_add2,
            kmem_web1, kmem_web2, wmem_web1, wmem_web2,
            kmem_oeb1, kmem_oeb2, kmem_csb1, kmem_csb2,
            wmem_oeb1, wmem_oeb2, wmem_csb1, wmem_csb2,
            en, learn_done, cls_done};
  endfunction

  // Expected outputs from the model's mode, residency and kernel slot.
  function automatic logic [VW-1:0] exp_vec();
    int ka1, ka2, wa1, wa2;
    logic kw1, kw2, ww1, ww2, ko1, ko2, kc1, kc2, wo1, wo2, wc1, wc2, e, ld, cd;
    ka1 = 0; ka2 = 0; wa1 = 0; wa2 = 0;
    kw1 = 1; kw2 = 1; ww1 = 1; ww2 = 1;
    ko1 = 0; ko2 = 0; kc1 = 0; kc2 = 0; wo1 = 0; wo2 = 0; wc1 = 0; wc2 = 0;
    e = 0; ld = 0; cd = 0;
    if (m_mode == 1) begin
      ka1 = (m_k * L_LEN + (m_n % L_LEN)) % AMOD;
      ka2 = ka1;
      wa1 = (2 * (m_n % L_LEN)) % AMOD;
      wa2 = (2 * (m_n % L_LEN) + 1) % AMOD;
      kw1 = 0; ww1 = 0; ww2 = 0;
      ld  = ((m_n % L_LEN) == L_LEN - 1);
`ifdef NN_CTRL_CSB_GATE_EN
      ko1 = 1; wo1 = 1; wo2 = 1;
`endif
    end else if (m_mode == 2) begin
      ka1 = (2 * m_k) % AMOD;
      ka2 = (2 * m_k + 1) % AMOD;
      wa1 = m_n % C_LEN;
      wa2 = wa1;
      e   = ((m_n % C_LEN) == 0);
      cd  = ((m_n % C_LEN) == C_LEN - 1);
    end else begin
`ifdef NN_CTRL_CSB_GATE_EN
      ko1 = 1; ko2 = 1; kc1 = 1; kc2 = 1; wo1 = 1; wo2 = 1; wc1 = 1; wc2 = 1;
`endif
    end
    return {5'(ka1), 5'(ka2), 5'(wa1), 5'(wa2), kw1, kw2, ww1, ww2,
            ko1, ko2, kc1, kc2, wo1, wo2, wc1, wc2, e, ld, cd};
  endfunction

  // One clock: apply inputs, advance the model at the edge, settle 1 time unit after.
  task automatic step(input logic l, input logic c, input logic r, input logic [2:0] ks);
    int nm;
    learn = l; classify = c; rst = r; kern_sel = ks;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_n = 0; m_k = 0;
    end else begin
      nm = l ? 1 : (c ? 2 : 0);
      if (nm != m_mode) begin
        m_n = 0;
        if (nm != 0) m_k = (int'(ks) > NK - 1) ? NK - 1 : int'(ks);
      end else begin
        m_n = m_n + 1;
      end
      m_mode = nm;
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 1, 3'd0);
    n_total++;
    if (act_vec() !== exp_vec()) $display("FAIL reset_vec act=%h exp=%h", act_vec(), exp_vec());
    else n_pass++;
    n_total++;
    if ({kmem_web1, kmem_web2, wmem_web1, wmem_web2, en, learn_done, cls_done} !== 7'b1111000)
      $display("FAIL reset_ctl act=%b exp=1111000",
               {kmem_web1, kmem_web2, wmem_web1, wmem_web2, en, learn_done, cls_done});
    else n_pass++;
  endtask

  task automatic test_learn_burst();
    int ka[5]  = '{8, 9, 10, 11, 8};
    int w1[5]  = '{0, 2, 4, 6, 0};
    int w2[5]  = '{1, 3, 5, 7, 1};
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 3'd2);
      n_total++;
      if (int'(kmem_add1) !== ka[i] || int'(wmem_add1) !== w1[i] || int'(wmem_add2) !== w2[i] ||
          learn_done !== (i == 3))
        $display("FAIL learn_burst[%0d] act ka1=%0d wa1=%0d wa2=%0d ld=%b exp %0d %0d %0d %b",
                 i, kmem_add1, wmem_add1, wmem_add2, learn_done, ka[i], w1[i], w2[i], (i == 3));
      else n_pass++;
      n_total++;
      if (act_vec() !== exp_vec()) $display("FAIL learn_vec[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      else n_pass++;
    end
    step(0, 0, 0, 3'd0);
  endtask

  task automatic test_classify();
    int w1[6] = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 3'd1);
      n_total++;
      if (int'(kmem_add1) !== 2 || int'(kmem_add2) !== 3 || int'(wmem_add1) !== w1[i] ||
          en !== (i == 0 || i == 4) || cls_done !== (i == 3))
        $display("FAIL classify[%0d] act ka1=%0d ka2=%0d wa1=%0d en=%b cd=%b exp 2 3 %0d %b %b",
                 i, kmem_add1, kmem_add2, wmem_add1, en, cls_done, w1[i], (i == 0 || i == 4), (i == 3));
      else n_pass++;
      n_total++;
      if (act_vec() !== exp_vec()) $display("FAIL cls_vec[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      else n_pass++;
    end
    step(0, 0, 0, 3'd0);
  endtask

  task automatic test_preempt();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3'd0);
    n_total++;
    if (int'(wmem_add1) !== 2) $display("FAIL preempt_rc act=%0d exp=2", wmem_add1);
    else n_pass++;
    step(1, 1, 0, 3'd0);
    n_total++;
    if (kmem_web1 !== 1'b0 || int'(wmem_add1) !== 0 || int'(wmem_add2) !== 1)
      $display("FAIL preempt_learn act web1=%b wa1=%0d wa2=%0d exp 0 0 1", kmem_web1, wmem_add1, wmem_add2);
    else n_pass++;
    step(0, 1, 0, 3'd0);
    n_total++;
    if (int'(wmem_add1) !== 0 || wmem_web1 !== 1'b1 || en !== 1'b1)
      $display("FAIL preempt_back act wa1=%0d wweb1=%b en=%b exp 0 1 1", wmem_add1, wmem_web1, en);
    else n_pass++;
    step(0, 0, 0, 3'd0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 3'd1);
    n_total++;
    if (int'(wmem_add1) !== 4) $display("FAIL midrst_wc act=%0d exp=4", wmem_add1);
    else n_pass++;
    step(1, 0, 1, 3'd1);
    n_total++;
    if ({kmem_web1, kmem_web2, wmem_web1, wmem_web2} !== 4'b1111 ||
        {kmem_add1, kmem_add2, wmem_add1, wmem_add2} !== 20'd0)
      $display("FAIL midrst_idle act webs=%b addrs=%h exp 1111 00000",
               {kmem_web1, kmem_web2, wmem_web1, wmem_web2}, {kmem_add1, kmem_add2, wmem_add1, wmem_add2});
    else n_pass++;
    step(1, 0, 0, 3'd1);
    n_total++;
    if (int'(wmem_add1) !== 0 || int'(kmem_add1) !== 4)
      $display("FAIL midrst_reentry act wa1=%0d ka1=%0d exp 0 4", wmem_add1, kmem_add1);
    else n_pass++;
    step(0, 0, 0, 3'd0);
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 3'd7);
      n_total++;
      if (int'(kmem_add1) !== 12 + i) $display("FAIL clamp_learn[%0d] act=%0d exp=%0d", i, kmem_add1, 12 + i);
      else n_pass++;
    end
    step(0, 1, 0, 3'd7);
    n_total++;
    if (int'(kmem_add1) !== 6 || int'(kmem_add2) !== 7)
      $display("FAIL clamp_cls act ka1=%0d ka2=%0d exp 6 7", kmem_add1, kmem_add2);
    else n_pass++;
    step(0, 0, 0, 3'd0);
  endtask

  task automatic test_csb();
    logic [7:0] idle_exp;
`ifdef NN_CTRL_CSB_GATE_EN
    idle_exp = 8'hFF;
`else
    idle_exp = 8'h00;
`endif
    step(0, 0, 0, 3'd0);
    n_total++;
    if ({kmem_oeb1, kmem_oeb2, kmem_csb1, kmem_csb2, wmem_oeb1, wmem_oeb2, wmem_csb1, wmem_csb2} !== idle_exp)
      $display("FAIL csb_idle act=%b exp=%b",
               {kmem_oeb1, kmem_oeb2, kmem_csb1, kmem_csb2, wmem_oeb1, wmem_oeb2, wmem_csb1, wmem_csb2}, idle_exp);
    else n_pass++;
    step(1, 0, 0, 3'd0);
    n_total++;
    if ({kmem_csb1, kmem_csb2, wmem_csb1, wmem_csb2} !== 4'b0000)
      $display("FAIL csb_learn act=%b exp=0000", {kmem_csb1, kmem_csb2, wmem_csb1, wmem_csb2});
    else n_pass++;
    step(0, 1, 0, 3'd0);
    n_total++;
    if ({kmem_csb1, kmem_csb2, wmem_csb1, wmem_csb2, kmem_oeb1, kmem_oeb2, wmem_oeb1, wmem_oeb2} !== 8'h00)
      $display("FAIL csb_cls act=%b exp=00000000",
               {kmem_csb1, kmem_csb2, wmem_csb1, wmem_csb2, kmem_oeb1, kmem_oeb2, wmem_oeb1, wmem_oeb2});
    else n_pass++;
    step(0, 0, 0, 3'd0);
  endtask

  task automatic test_random();
    logic l, c, r;
    logic [2:0] ks;
    for (int i = 0; i < 400; i++) begin
      l  = ($urandom_range(0, 9) < 3);
      c  = ($urandom_range(0, 9) < 6);
      r  = ($urandom_range(0, 49) == 0);
      ks = 3'($urandom_range(0, 7));
      step(l, c, r, ks);
      n_total++;
      if (act_vec() !== exp_vec())
        $display("FAIL random[%0d] act=%h exp=%h mode=%0d n=%0d k=%0d", i, act_vec(), exp_vec(), m_mode, m_n, m_k);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    m_mode = 0; m_n = 0; m_k = 0;
    rst = 1'b1; learn = 1'b0; classify = 1'b0; kern_sel = 3'd0;
    test_reset();
    test_learn_burst();
    test_classify();
    test_preempt();
    test_reset_mid();
    test_clamp();
    test_csb();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
